sdrc_traffic_gen: RTL

- Synthesizable, parametrised write/read traffic generator and checker for the sdrc_core application interface.
- Replaces hand-scripted burst tasks with self-checking traffic that runs in silicon or simulation:
  - issues batches of write bursts with pseudo-random address, length and LFSR data;
  - reads the batch back in issue order and compares against regenerated data.
- Sits between a config/CSR block and sdrc_core's app_* port. It is muxed with the normal application master.

---
 rtl/sdrc_tg_pkg.sv | 34 +++
 rtl/sdrc_tg_cmdq.sv | 47 ++++
 rtl/sdrc_traffic_gen.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sdrc_tg_pkg.sv
// sdrc_tg_pkg: shared types and helpers for the sdrc_core traffic generator.
//   tg_state_t  - generator FSM states
//   LFSR_POLY   - 32-bit Galois LFSR feedback polynomial
//   lfsr_next   - one Galois (right-shift) LFSR step
//   tg_qent_t   - command-queue entry {addr, len, seed}
package sdrc_tg_pkg;

    // Burst-length field width carried in the queue entry; the top-level
    // LEN_W parameter must match it.
    localparam int TG_LEN_W = 9;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_DATA,
        RD_REQ,
        RD_DATA,
        NEXT,
        DONE
    } tg_state_t;

    typedef struct packed {
        logic [29:0]         addr;
        logic [TG_LEN_W-1:0] len;
        logic [31:0]         seed;   // data LFSR state at the first beat
    } tg_qent_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/sdrc_tg_cmdq.sv
// sdrc_tg_cmdq: synchronous FIFO of issued write bursts, replayed as reads.
//   clk, reset_n  - clock, asynchronous active-low reset (empties the queue)
//   push, din     - write an entry
//   pop, dout     - dout shows the head entry; pop discards it
//   full, empty   - occupancy flags
module sdrc_tg_cmdq
    import sdrc_tg_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  tg_qent_t din,
    input  logic     pop,
    output tg_qent_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    tg_qent_t        mem [DEPTH];
    logic [AW:0]     wp;
    logic [AW:0]     rp;

    // Extra pointer MSB distinguishes full from empty.
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + (AW+1)'(1);
            if (pop)  rp <= rp + (AW+1)'(1);
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sdrc_traffic_gen.sv
// sdrc_traffic_gen: self-checking write/read traffic generator for the
// sdrc_core app_* interface.
//   clk, reset_n                 - clock, asynchronous active-low reset
//   start, cfg_*                 - run control: batches, bursts/batch, seed, masks
//   app_req*, app_wr_*, app_rd_* - sdrc_core application port (master side)
//   busy, done                   - run status (done sticky until next start)
//   err_cnt, first_err_*         - saturating error count, first error location
// Beat indices reported in first_err_beat are 1-based (beat len = last beat).
// Per burst the address LFSR is used then stepped for the address, and used
// then stepped again for the length.
module sdrc_traffic_gen
    import sdrc_tg_pkg::*;
#(
    parameter int APP_DW = 32,
    parameter int QDEPTH = 8,
    parameter int LEN_W  = TG_LEN_W,
    parameter int ITER_W = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ITER_W-1:0]       cfg_iter,
    input  logic [$clog2(QDEPTH):0] cfg_batch,
    input  logic [31:0]             cfg_seed,
    input  logic [29:0]             cfg_addr_mask,
    input  logic [LEN_W-1:0]        cfg_len_mask,
    output logic                    app_req,
    output logic [29:0]             app_req_addr,
    output logic [LEN_W-1:0]        app_req_len,
    output logic                    app_req_wr_n,
    input  logic                    app_req_ack,
    output logic [APP_DW-1:0]       app_wr_data,
    output logic [APP_DW/8-1:0]     app_wr_en_n,
    input  logic                    app_wr_next_req,
    input  logic                    app_rd_valid,
    input  logic                    app_last_rd,
    input  logic [APP_DW-1:0]       app_rd_data,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             err_cnt,
    output logic [29:0]             first_err_addr,
    output logic [LEN_W-1:0]        first_err_beat
);

    localparam int BW = $clog2(QDEPTH) + 1;

    tg_state_t         state;
    logic [31:0]       addr_lfsr, data_lfsr, rd_lfsr;
    logic [ITER_W-1:0] iter_cnt;
    logic [BW-1:0]     batch_n, wr_issued, eff_batch;
    logic [LEN_W-1:0]  beat;

    logic [31:0]       a_seed_cfg, d_seed_cfg, a_cur, a_mid, d_step, launch_seed;
    logic [29:0]       gen_addr;
    logic [LEN_W-1:0]  gen_len;
    logic              last_beat, launch_wr, launch_rd, rd_fin;
    logic              rd_mis, proto_err;
    logic [1:0]        n_err;
    logic [16:0]       err_sum;
    logic [15:0]       err_nxt;

    tg_qent_t          q_din, q_head;
    logic              q_full, q_empty;

    assign a_seed_cfg = (~cfg_seed == 32'd0) ? 32'd1 : ~cfg_seed;
    assign d_seed_cfg = (cfg_seed == 32'd0) ? 32'd1 : cfg_seed;
    // From IDLE the LFSRs are not loaded yet, so draw from the seeds directly.
    assign a_cur      = (state == IDLE) ? a_seed_cfg : addr_lfsr;
    assign a_mid      = lfsr_next(a_cur);
    assign d_step     = lfsr_next(data_lfsr);
    assign gen_addr   = a_cur[29:0] & cfg_addr_mask;
    assign gen_len    = (a_mid[LEN_W-1:0] & cfg_len_mask) + LEN_W'(1);
    assign last_beat  = (beat == app_req_len - LEN_W'(1));

    always_comb begin
        if (cfg_batch == '0)               eff_batch = BW'(1);
        else if (cfg_batch > BW'(QDEPTH))  eff_batch = BW'(QDEPTH);
        else                               eff_batch = cfg_batch;
    end

    // Transitions that start a new write burst / read burst, or end a batch.
    always_comb begin
        launch_wr   = 1'b0;
        launch_rd   = 1'b0;
        rd_fin      = 1'b0;
        launch_seed = data_lfsr;
        unique case (state)
            IDLE: begin
                launch_wr   = start && (cfg_iter != '0);
                launch_seed = d_seed_cfg;
            end
            WR_DATA: begin
                launch_seed = d_step;
                if (app_wr_next_req && last_beat) begin
                    launch_wr = (wr_issued != batch_n);
                    launch_rd = (wr_issued == batch_n);
                end
            end
            RD_DATA: begin
                if (app_rd_valid && last_beat) begin
                    launch_rd = !q_empty;
                    rd_fin    = q_empty;
                end
            end
            NEXT:    launch_wr = (iter_cnt != ITER_W'(1));
            default: ;
        endcase
    end

    assign q_din = '{addr: gen_addr, len: gen_len, seed: launch_seed};

    // Read-beat checking: data miscompare and last-beat marker errors.
    assign rd_mis    = (app_rd_data != rd_lfsr[APP_DW-1:0]);
    assign proto_err = (app_last_rd != last_beat);
    assign n_err     = {1'b0, rd_mis} + {1'b0, proto_err};
    assign err_sum   = {1'b0, err_cnt} + {15'd0, n_err};
    assign err_nxt   = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    sdrc_tg_cmdq #(.DEPTH(QDEPTH)) u_cmdq (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (launch_wr),
        .din    (q_din),
        .pop    (launch_rd),
        .dout   (q_head),
        .full   (q_full),
        .empty  (q_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            addr_lfsr      <= '0;
            data_lfsr      <= '0;
            rd_lfsr        <= '0;
            iter_cnt       <= '0;
            batch_n        <= '0;
            wr_issued      <= '0;
            beat           <= '0;
            app_req        <= 1'b0;
            app_req_addr   <= '0;
            app_req_len    <= '0;
            app_req_wr_n   <= 1'b1;
            app_wr_data    <= '0;
            app_wr_en_n    <= '1;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_beat <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    done           <= 1'b0;
                    err_cnt        <= '0;
                    first_err_addr <= '0;
                    first_err_beat <= '0;
                    iter_cnt       <= cfg_iter;
                    batch_n        <= eff_batch;
                    if (cfg_iter == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        busy  <= 1'b1;
                    end
                end
                WR_REQ, RD_REQ: if (app_req_ack) begin
                    app_req <= 1'b0;
                    state   <= (state == WR_REQ) ? WR_DATA : RD_DATA;
                end
                WR_DATA: if (app_wr_next_req) begin
                    data_lfsr   <= d_step;
                    app_wr_data <= d_step[APP_DW-1:0];
                    beat        <= beat + LEN_W'(1);
                    if (last_beat) app_wr_en_n <= '1;
                end
                RD_DATA: if (app_rd_valid) begin
                    rd_lfsr <= lfsr_next(rd_lfsr);
                    beat    <= beat + LEN_W'(1);
                    err_cnt <= err_nxt;
                    if (n_err != 2'd0 && err_cnt == '0) begin
                        first_err_addr <= app_req_addr;
                        first_err_beat <= beat + LEN_W'(1);
                    end
                    if (rd_fin) state <= NEXT;
                end
                NEXT: begin
                    iter_cnt <= iter_cnt - ITER_W'(1);
                    if (iter_cnt == ITER_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Launch a write burst: draw address/length, record it for replay.
            if (launch_wr) begin
                state        <= WR_REQ;
                app_req      <= 1'b1;
                app_req_wr_n <= 1'b0;
                app_req_addr <= gen_addr;
                app_req_len  <= gen_len;
                app_wr_data  <= launch_seed[APP_DW-1:0];
                app_wr_en_n  <= '0;
                data_lfsr    <= launch_seed;
                addr_lfsr    <= lfsr_next(a_mid);
                beat         <= '0;
                wr_issued    <= (state == WR_DATA) ? wr_issued + BW'(1) : BW'(1);
            end

            // Launch a read burst; the request registers double as the
            // working copy of the popped entry.
            if (launch_rd) begin
                state        <= RD_REQ;
                app_req      <= 1'b1;
                app_req_wr_n <= 1'b1;
                app_req_addr <= q_head.addr;
                app_req_len  <= q_head.len;
                rd_lfsr      <= q_head.seed;
                beat         <= '0;
            end
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
        !(launch_wr && q_full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n)
        !(launch_rd && q_empty));

endmodule
